serial_fir: RTL and testbench
=============================

# serial_fir

Time-multiplexed 16-tap FIR filter using a single multiply-accumulate unit. One input sample is accepted per enable pulse. The 16 tap products are accumulated over the following 16 clock cycles, and the result is registered on the output. It sits in the DSP datapath behind a sample-rate strobe (fs = f_clk/16 or slower) and feeds downstream signed processing.

## Interface
- TAPS, 16: number of taps (power of two); also the MAC cycles per sample
- DATA_W, 12: input sample width, signed two's complement
- COEF_W, 11: coefficient width, signed
- OUT_W, 27: output width, equal to DATA_W+COEF_W+$clog2(TAPS)
- clk_i  input  1  clock, all logic on rising edge
- rstn_i  input  1  reset, asynchronous, active-low
- enable_i  input  1  sample strobe; data_i is captured when high and the block is idle
- data_i  input  DATA_W  input sample, interpreted signed
- data_o  output  OUT_W  signed filter result, held between updates

## Operation
- Delay line: TAPS registers of DATA_W. On an accepted enable, x[0] takes data_i and x[k] takes x[k-1].
- Coefficients are constants c[0..15]: -3, -8, 0, 28, 64, 110, 150, 172, 172, 150, 110, 64, 28, 0, -8, -3 (symmetric low-pass, sum 1026).
- y = Σ c[k]·x[k], where x[0] is the newest sample.
- MAC:
  - Each product is signed DATA_W×COEF_W, sign-extended to OUT_W before adding.
  - The accumulator is OUT_W wide and has no saturation. It cannot overflow for legal inputs.
  - No rounding or truncation is applied.
- FSM:
  - IDLE: on enable_i, shift the line, clear the accumulator and set tap counter = 0, then go to BUSY.
  - BUSY: each cycle, acc += c[cnt]·x[cnt] and cnt++. When cnt = TAPS-1, data_o <= acc + final product, then go to IDLE.
- An enable_i arriving in BUSY before the last MAC cycle is ignored; the sample is dropped and the delay line is unchanged.
- An enable_i in the same cycle as the last MAC cycle is accepted:
  - data_o is written with the finished result.
  - The line shifts and a new computation starts (back-to-back operation, period 16).
- Reset clears:
  - the delay line, accumulator and counter to 0
  - FSM to IDLE
  - data_o to 0
- Reset mid-computation aborts the computation without updating data_o.

## Timing
- Edge E0 samples enable_i=1, and x[0] is loaded.
- Edges E1..E16 perform products k=0..15.
- data_o changes at E16, so latency is 16 clocks from the capture edge.
- data_o is stable for at least 16 cycles after each update.
- Minimum enable spacing is 16 clocks. Shorter spacing drops samples as described above.
- data_i only needs to be valid on the enable edge.

## Configuration
- SERIAL_FIR_VALID_EN:
  - Defined: adds output port valid_o (1 bit, reset 0). It pulses high for exactly one cycle, the cycle after data_o updates, in which the new data_o is present.
  - Undefined: the port and its logic are absent, and the interface is exactly the list above.

## Structure
- Package serial_fir_pkg holds:
  - TAPS, DATA_W, COEF_W and OUT_W defaults
  - the coefficient array constant
  - the FSM state enum (IDLE, BUSY)
- Sub-module serial_fir_mac contains the signed multiplier, sign extension and accumulator, with clear and accumulate controls. The top module contains the delay line, counter, FSM and output register.

## Test plan
- Reset: hold rstn_i low, toggle enable_i and data_i -> data_o = 0 (valid_o = 0), with no updates.
- Impulse:
  - Stimulus: data_i = 1 then 0 on successive enables spaced 16 cycles.
  - Required: data_o sequence -3, -8, 0, 28, 64, 110, 150, 172, 172, 150, 110, 64, 28, 0, -8, -3, then 0.
- Step extremes:
  - Repeated 2047 -> settles to 2100222.
  - Repeated -2048 -> settles to -2101248.
  - No wrap in either case.
- Latency and back-to-back:
  - Enables every 16 cycles -> data_o changes exactly 16 edges after each capture edge, with no dropped samples.
- Early enable:
  - An enable issued 5 cycles after a capture is ignored, and the output equals the result computed without that enable.
- Async reset mid-BUSY:
  - Assert rstn_i at MAC cycle 8 -> data_o drops to 0 immediately.
  - After release, the first enable gives an output based on a cleared history: impulse 1 -> -3.

Source files
------------

// File: rtl/serial_fir_pkg.sv
// Shared constants, coefficient table and FSM encoding for the serial FIR.
package serial_fir_pkg;

  localparam int TAPS   = 16;
  localparam int DATA_W = 12;
  localparam int COEF_W = 11;
  localparam int CNT_W  = $clog2(TAPS);
  localparam int OUT_W  = DATA_W + COEF_W + CNT_W;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Symmetric low-pass, DC gain 1026.
  function automatic logic signed [COEF_W-1:0] coef(input logic [CNT_W-1:0] idx);
    case (idx)
      4'd0:    coef = -11'sd3;
      4'd1:    coef = -11'sd8;
      4'd2:    coef = 11'sd0;
      4'd3:    coef = 11'sd28;
      4'd4:    coef = 11'sd64;
      4'd5:    coef = 11'sd110;
      4'd6:    coef = 11'sd150;
      4'd7:    coef = 11'sd172;
      4'd8:    coef = 11'sd172;
      4'd9:    coef = 11'sd150;
      4'd10:   coef = 11'sd110;
      4'd11:   coef = 11'sd64;
      4'd12:   coef = 11'sd28;
      4'd13:   coef = 11'sd0;
      4'd14:   coef = -11'sd8;
      default: coef = -11'sd3;
    endcase
  endfunction

endpackage

// File: rtl/serial_fir_mac.sv
// Signed multiply-accumulate: sum_o = acc + ext(sample*coef), combinational off the accumulator.
// clr_i wins over acc_en_i so a back-to-back restart always begins from zero.
module serial_fir_mac #(
  parameter int DATA_W = serial_fir_pkg::DATA_W,
  parameter int COEF_W = serial_fir_pkg::COEF_W,
  parameter int OUT_W  = serial_fir_pkg::OUT_W
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clr_i,
  input  logic                     acc_en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [OUT_W-1:0]  sum_o
);
  import serial_fir_pkg::*;

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  prod_ext;
  logic signed [OUT_W-1:0]  acc_q;
  logic signed [OUT_W-1:0]  acc_d;

  assign prod     = $signed({{COEF_W{sample_i[DATA_W-1]}}, sample_i})
                  * $signed({{DATA_W{coef_i[COEF_W-1]}}, coef_i});
  assign prod_ext = {{(OUT_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum_o    = acc_q + prod_ext;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/serial_fir.sv
// 16-tap FIR on one MAC: sample captured on enable, result on data_o 16 clocks later.
// Enables during BUSY are dropped except on the last MAC cycle; SERIAL_FIR_VALID_EN adds valid_o.
module serial_fir #(
  parameter int TAPS   = serial_fir_pkg::TAPS,
  parameter int DATA_W = serial_fir_pkg::DATA_W,
  parameter int COEF_W = serial_fir_pkg::COEF_W,
  parameter int OUT_W  = serial_fir_pkg::OUT_W
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [OUT_W-1:0]  data_o
`ifdef SERIAL_FIR_VALID_EN
  ,
  output logic                     valid_o
`endif
);
  import serial_fir_pkg::*;

  localparam int CW = $clog2(TAPS);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [OUT_W-1:0]  data_q;
  logic signed [OUT_W-1:0]  mac_sum;
  logic signed [COEF_W-1:0] coef_cur;
  logic                     shift, mac_clr, mac_en, last;

  assign coef_cur = coef(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift   = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          shift   = 1'b1;
          mac_clr = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mac_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(TAPS - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
          // Last MAC cycle doubles as the capture edge of the next sample.
          if (enable_i) begin
            shift   = 1'b1;
            mac_clr = 1'b1;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (shift) begin
        x_q[0] <= data_i;
        for (int k = 1; k < TAPS; k++) begin
          x_q[k] <= x_q[k-1];
        end
      end
      if (last) begin
        data_q <= mac_sum;
      end
    end
  end

  assign data_o = data_q;

  serial_fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (mac_clr),
    .acc_en_i (mac_en),
    .sample_i (x_q[cnt_q]),
    .coef_i   (coef_cur),
    .sum_o    (mac_sum)
  );

`ifdef SERIAL_FIR_VALID_EN
  logic valid_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= last;
    end
  end

  assign valid_o = valid_q;
`endif

endmodule

// File: tb/tb_serial_fir.sv
// Bench for serial_fir: impulse table, step extremes, back-to-back random stream,
// early enable, async reset mid-computation; expectations from a tap-history model.
module tb_serial_fir;

  logic               clk_i;
  logic               rstn_i;
  logic               enable_i;
  logic signed [11:0] data_i;
  logic signed [26:0] data_o;
`ifdef SERIAL_FIR_VALID_EN
  logic               valid_o;
`endif

  serial_fir dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .enable_i (enable_i),
    .data_i   (data_i),
    .data_o   (data_o)
`ifdef SERIAL_FIR_VALID_EN
    ,
    .valid_o  (valid_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int din;
    int exp;
  } vec_t;

  int coef_tab [16] = '{-3, -8, 0, 28, 64, 110, 150, 172, 172, 150, 110, 64, 28, 0, -8, -3};
  int imp_exp  [17] = '{-3, -8, 0, 28, 64, 110, 150, 172, 172, 150, 110, 64, 28, 0, -8, -3, 0};
  int hist [16];
  int held;
  int n_total;
  int n_pass;

  task automatic check(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 16; k++) hist[k] = 0;
  endfunction

  function automatic void model_push(input int d);
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
  endfunction

  function automatic int model_y();
    int s = 0;
    for (int k = 0; k < 16; k++) s += coef_tab[k] * hist[k];
    return s;
  endfunction

  function automatic int rand_sample();
    int v = int'($urandom_range(0, 4095));
    if (v > 2047) v -= 4096;
    return v;
  endfunction

  // Single isolated sample; checks output holds through E15 and updates at E16.
  task automatic send_one(input int d, input int exp, input string nm);
    enable_i = 1'b1;
    data_i   = 12'(d);
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    data_i   = 12'($urandom);
    repeat (15) @(posedge clk_i);
    #1;
    check({nm, "_hold"}, int'(data_o), held);
    @(posedge clk_i); #1;
    check(nm, int'(data_o), exp);
`ifdef SERIAL_FIR_VALID_EN
    check({nm, "_valid_hi"}, int'(valid_o), 1);
`endif
    held = exp;
    @(posedge clk_i); #1;
`ifdef SERIAL_FIR_VALID_EN
    check({nm, "_valid_lo"}, int'(valid_o), 0);
`endif
  endtask

  // Back-to-back samples at period 16: each next enable lands on the last MAC edge.
  task automatic stream(input int samp[$], input string nm);
    int exp;
    model_push(samp[0]);
    exp      = model_y();
    enable_i = 1'b1;
    data_i   = 12'(samp[0]);
    @(posedge clk_i); #1;
    for (int i = 0; i < samp.size(); i++) begin
      enable_i = 1'b0;
      data_i   = 12'($urandom);
      repeat (15) @(posedge clk_i);
      #1;
      check({nm, "_hold"}, int'(data_o), held);
      if (i + 1 < samp.size()) begin
        enable_i = 1'b1;
        data_i   = 12'(samp[i+1]);
      end
      @(posedge clk_i); #1;
      check(nm, int'(data_o), exp);
`ifdef SERIAL_FIR_VALID_EN
      check({nm, "_valid"}, int'(valid_o), 1);
`endif
      held = exp;
      if (i + 1 < samp.size()) begin
        model_push(samp[i+1]);
        exp = model_y();
      end
    end
    enable_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic early_enable(input int d);
    int exp;
    model_push(d);
    exp      = model_y();
    enable_i = 1'b1;
    data_i   = 12'(d);
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    enable_i = 1'b1;
    data_i   = 12'sh5a5;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check("early_hold", int'(data_o), held);
    @(posedge clk_i); #1;
    check("early_out", int'(data_o), exp);
    held = exp;
    @(posedge clk_i); #1;
  endtask

  initial begin
    vec_t vecs [17];
    int   q[$];
    int   d;

    n_total  = 0;
    n_pass   = 0;
    held     = 0;
    model_clear();
    rstn_i   = 1'b0;
    enable_i = 1'b0;
    data_i   = '0;

    for (int i = 0; i < 17; i++) begin
      vecs[i].din = (i == 0) ? 1 : 0;
      vecs[i].exp = imp_exp[i];
    end

    for (int i = 0; i < 6; i++) begin
      enable_i = ~enable_i;
      data_i   = 12'($urandom);
      @(posedge clk_i); #1;
      check("reset_data", int'(data_o), 0);
`ifdef SERIAL_FIR_VALID_EN
      check("reset_valid", int'(valid_o), 0);
`endif
    end
    enable_i = 1'b0;
    rstn_i   = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("post_reset_idle", int'(data_o), 0);

    for (int i = 0; i < 17; i++) begin
      model_push(vecs[i].din);
      send_one(vecs[i].din, vecs[i].exp, "impulse");
    end

    q.delete();
    repeat (16) q.push_back(2047);
    stream(q, "step_pos");
    check("step_pos_final", int'(data_o), 2100222);

    q.delete();
    repeat (16) q.push_back(-2048);
    stream(q, "step_neg");
    check("step_neg_final", int'(data_o), -2101248);

    q.delete();
    repeat (24) q.push_back(rand_sample());
    stream(q, "rand_b2b");

    early_enable(rand_sample());
    for (int i = 0; i < 4; i++) begin
      d = rand_sample();
      model_push(d);
      send_one(d, model_y(), "rand_single");
    end

    // Force a large held value, then abort a computation at MAC cycle 8.
    q.delete();
    repeat (16) q.push_back(-2048);
    stream(q, "pre_abort");
    enable_i = 1'b1;
    data_i   = 12'sd1000;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    #1;
    check("abort_data_zero", int'(data_o), 0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    model_clear();
    held = 0;
    repeat (20) @(posedge clk_i);
    #1;
    check("abort_no_update", int'(data_o), 0);
    model_push(1);
    send_one(1, -3, "abort_impulse");
    check("abort_model", model_y(), int'(data_o));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
